// File: rtl/stopwatch_if.sv
// Board-pin bundle for the stopwatch: push-button inputs and
// the multiplexed 7-segment display outputs.
interface stopwatch_if;
  logic       button_start;
  logic       button_stop;
  logic [3:0] anode_signals;
  logic [6:0] display_out;

  modport master (
    output button_start,
    output button_stop,
    input  anode_signals,
    input  display_out
  );

  modport slave (
    input  button_start,
    input  button_stop,
    output anode_signals,
    output display_out
  );
endinterface

// File: rtl/stopwatch_top.sv
// SS.hh stopwatch: button sync, run flag, 100 Hz prescaler,
// four-digit BCD count and multiplexed 7-segment drive.
module stopwatch_top #(
  parameter int TICK_DIV    = 500000,
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        button_reset,
  stopwatch_if.slave  io
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

  logic            start_s1_q, start_s2_q;
  logic            stop_s1_q, stop_s2_q;
  logic            running_q, running_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            tick;
  logic [3:0][3:0] dig_q, dig_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      cur_dig;

  // Two-flop synchronizers for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (button_reset) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      stop_s1_q  <= 1'b0;
      stop_s2_q  <= 1'b0;
    end else begin
      start_s1_q <= io.button_start;
      start_s2_q <= start_s1_q;
      stop_s1_q  <= io.button_stop;
      stop_s2_q  <= stop_s1_q;
    end
  end

  // Run flag, prescaler and display scan next state
  always_comb begin
    running_d = running_q;
    if (stop_s2_q)
      running_d = 1'b0;
    else if (start_s2_q)
      running_d = 1'b1;

    tick  = 1'b0;
    pre_d = pre_q;
    if (running_q) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    idx_d = idx_q;
    ref_d = ref_q + 1'b1;
    if (ref_q == REF_MAX) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // BCD ripple: each digit wraps 9->0 and carries upward
  always_comb begin
    logic carry;
    dig_d = dig_q;
    carry = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_d[i] = 4'd0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  // State registers; reset clears count, phase and scan
  always_ff @(posedge clk) begin
    if (button_reset) begin
      running_q <= 1'b0;
      pre_q     <= '0;
      dig_q     <= '0;
      ref_q     <= '0;
      idx_q     <= 2'd0;
    end else begin
      running_q <= running_d;
      pre_q     <= pre_d;
      dig_q     <= dig_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
    end
  end

  // Active-low digit select and segment decode
  always_comb begin
    cur_dig          = dig_q[idx_q];
    io.anode_signals = ~(4'b0001 << idx_q);
    case (cur_dig)
      4'd0:    io.display_out = 7'b1000000;
      4'd1:    io.display_out = 7'b1111001;
      4'd2:    io.display_out = 7'b0100100;
      4'd3:    io.display_out = 7'b0110000;
      4'd4:    io.display_out = 7'b0011001;
      4'd5:    io.display_out = 7'b0010010;
      4'd6:    io.display_out = 7'b0000010;
      4'd7:    io.display_out = 7'b1111000;
      4'd8:    io.display_out = 7'b0000000;
      4'd9:    io.display_out = 7'b0010000;
      default: io.display_out = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_top.sv
// Directed bench for stopwatch_top with TICK_DIV=4,
// REFRESH_DIV=2; digits are read back via the anode scan.
module tb_stopwatch_top;
  logic clk;
  logic button_reset;
  int   tests;
  int   fails;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0010000;

  stopwatch_if sw ();

  stopwatch_top #(
    .TICK_DIV    (4),
    .REFRESH_DIV (2)
  ) dut (
    .clk          (clk),
    .button_reset (button_reset),
    .io           (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_digit(input int k, output logic [6:0] seg);
    logic [3:0] an;
    logic       found;
    an    = ~(4'b0001 << k);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (sw.anode_signals == an) found = 1'b1;
      else step(1);
    end
    check($sformatf("scan_d%0d", k), {31'd0, found}, 32'd1);
    seg = sw.display_out;
  endtask

  task automatic check_disp(input string tag,
                            input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] s;
    logic [6:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int k = 0; k < 4; k++) begin
      read_digit(k, s);
      check($sformatf("%s_d%0d", tag, k), {25'd0, s}, {25'd0, exp[k]});
    end
  endtask

  task automatic start_pulse();
    sw.button_start = 1'b1;
    step(1);
    sw.button_start = 1'b0;
    step(2);
  endtask

  task automatic stop_hold();
    sw.button_stop = 1'b1;
    step(3);
    sw.button_stop = 1'b0;
    step(3);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    button_reset    = 1'b1;
    sw.button_start = 1'b0;
    sw.button_stop  = 1'b0;

    step(2);
    check("rst_anode", {28'd0, sw.anode_signals}, 32'hE);
    check("rst_seg", {25'd0, sw.display_out}, {25'd0, S0});
    button_reset = 1'b0;
    check("rst_run", {31'd0, dut.running_q}, 32'd0);
    check_disp("rst", S0, S0, S0, S0);

    // start latency: high on the 3rd edge
    sw.button_start = 1'b1;
    step(1);
    sw.button_start = 1'b0;
    step(1);
    check("lat_e2", {31'd0, dut.running_q}, 32'd0);
    step(1);
    check("lat_e3", {31'd0, dut.running_q}, 32'd1);

    // 40 running edges + 3 during stop latency = 10 ticks
    step(40);
    stop_hold();
    check("stop_run", {31'd0, dut.running_q}, 32'd0);
    check_disp("c10", S0, S0, S1, S0);
    step(20);
    check_disp("hold", S0, S0, S1, S0);

    // resume: held phase 3 + 37 + 3 more edges = 20 ticks
    start_pulse();
    check("resume_run", {31'd0, dut.running_q}, 32'd1);
    step(37);
    stop_hold();
    check_disp("c20", S0, S0, S2, S0);

    // both buttons high: stays stopped, count unchanged
    sw.button_start = 1'b1;
    sw.button_stop  = 1'b1;
    step(3);
    check("both_run", {31'd0, dut.running_q}, 32'd0);
    step(10);
    sw.button_start = 1'b0;
    sw.button_stop  = 1'b0;
    step(3);
    check("both_run2", {31'd0, dut.running_q}, 32'd0);
    check_disp("both", S0, S0, S2, S0);

    // preload 9999 ticks = 39996 running edges
    button_reset = 1'b1;
    step(1);
    button_reset = 1'b0;
    start_pulse();
    step(39993);
    stop_hold();
    check_disp("c9999", S9, S9, S9, S9);

    // one more tick wraps to 00.00 and keeps running
    start_pulse();
    step(4);
    check("wrap_run", {31'd0, dut.running_q}, 32'd1);
    stop_hold();
    check_disp("wrap", S0, S0, S0, S0);

    // reset mid-run clears and stops
    start_pulse();
    step(10);
    button_reset = 1'b1;
    step(1);
    button_reset = 1'b0;
    check("mid_run", {31'd0, dut.running_q}, 32'd0);
    check("mid_anode", {28'd0, sw.anode_signals}, 32'hE);
    check("mid_seg", {25'd0, sw.display_out}, {25'd0, S0});
    step(20);
    check("mid_run2", {31'd0, dut.running_q}, 32'd0);
    check_disp("mid", S0, S0, S0, S0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
